// File: rtl/fb_pkg.sv
// Shared defaults and FSM state type for the column framebuffer.
// Imported by the reader and the top level.
package fb_pkg;

    localparam int N_DRIVERS_DEF  = 16;
    localparam int PIXEL_W_DEF    = 24;
    localparam int MUX_DEF        = 8;
    localparam int RAM_ADDR_W_DEF = 7;
    localparam int RAM_LAT_DEF    = 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SWAP_WAIT
    } fill_state_t;

endpackage

// File: rtl/fb_ram_reader.sv
// Column address generator plus a RAM_LAT-deep tag pipe that
// labels each returning RAM word with its driver index.
module fb_ram_reader
    import fb_pkg::*;
#(
    parameter int N_DRIVERS  = N_DRIVERS_DEF,
    parameter int PIXEL_W    = PIXEL_W_DEF,
    parameter int MUX        = MUX_DEF,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
    parameter int RAM_LAT    = RAM_LAT_DEF,
    parameter int CNT_W      = $clog2(N_DRIVERS + 1),
    parameter int COL_W      = $clog2(MUX)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clk_enable,
    input  logic                  flush,
    input  logic                  start,
    input  logic [COL_W-1:0]      start_col,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    input  logic [PIXEL_W-1:0]    ram_data,
    output logic                  wr_en,
    output logic [CNT_W-1:0]      wr_idx,
    output logic [PIXEL_W-1:0]    wr_data,
    output logic                  fill_done
);

    logic [COL_W-1:0]      col_r;
    logic [CNT_W-1:0]      cnt;
    logic                  iss_v;
    logic [CNT_W-1:0]      iss_idx;
    logic [RAM_LAT-1:0]    pv;
    logic [CNT_W-1:0]      pidx [RAM_LAT];
    logic [RAM_ADDR_W-1:0] addr_next;

    assign addr_next = RAM_ADDR_W'(col_r)
                     + RAM_ADDR_W'(cnt) * RAM_ADDR_W'(MUX);

    // Issue one address per enabled cycle and shift the tag pipe alongside
    always_ff @(posedge clk) begin
        if (!nrst) begin
            ram_addr <= '0;
            col_r    <= '0;
            cnt      <= CNT_W'(N_DRIVERS);
            iss_v    <= 1'b0;
            iss_idx  <= '0;
            pv       <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                pidx[i] <= '0;
            end
        end else begin
            if (flush) begin
                pv <= '0;
            end else if (clk_enable) begin
                pv[0]   <= iss_v;
                pidx[0] <= iss_idx;
                for (int i = 1; i < RAM_LAT; i++) begin
                    pv[i]   <= pv[i-1];
                    pidx[i] <= pidx[i-1];
                end
            end
            if (start) begin
                col_r    <= start_col;
                ram_addr <= RAM_ADDR_W'(start_col);
                iss_v    <= 1'b1;
                iss_idx  <= '0;
                cnt      <= CNT_W'(1);
            end else if (clk_enable) begin
                if (cnt < CNT_W'(N_DRIVERS)) begin
                    ram_addr <= addr_next;
                    iss_v    <= 1'b1;
                    iss_idx  <= cnt;
                    cnt      <= cnt + 1'b1;
                end else begin
                    iss_v <= 1'b0;
                end
            end
        end
    end

    // Words still in flight when a frame restarts are discarded
    assign wr_en     = pv[RAM_LAT-1] & clk_enable & ~flush;
    assign wr_idx    = pidx[RAM_LAT-1];
    assign wr_data   = ram_data;
    assign fill_done = wr_en && (wr_idx == CNT_W'(N_DRIVERS - 1));

endmodule

// File: rtl/column_framebuffer_mp.sv
// Double-buffered multiplex column store: back buffer fills from RAM,
// front buffer drives the LED driver chain.
module column_framebuffer_mp
    import fb_pkg::*;
#(
    parameter int N_DRIVERS  = N_DRIVERS_DEF,
    parameter int PIXEL_W    = PIXEL_W_DEF,
    parameter int MUX        = MUX_DEF,
    parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
    parameter int RAM_LAT    = RAM_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           clk_enable,
    input  logic                           SOF,
    input  logic                           EOC,
    output logic [N_DRIVERS*PIXEL_W-1:0]   data_out,
    output logic                           data_valid,
    output logic                           driver_SOF,
    output logic                           EOR,
    output logic                           underrun,
    output logic [RAM_ADDR_W-1:0]          ram_addr,
    input  logic [PIXEL_W-1:0]             ram_data
);

    localparam int CNT_W = $clog2(N_DRIVERS + 1);
    localparam int COL_W = $clog2(MUX);
    localparam int BUF_W = N_DRIVERS * PIXEL_W;

    logic [BUF_W-1:0]   buf0;
    logic [BUF_W-1:0]   buf1;
    logic               front_sel;
    fill_state_t        state;
    logic [COL_W-1:0]   col;
    logic               pend;

    logic               wr_en;
    logic [CNT_W-1:0]   wr_idx;
    logic [PIXEL_W-1:0] wr_data;
    logic               fill_done;
    logic               ready;
    logic               swap;
    logic               last_col;
    logic               start;
    logic [COL_W-1:0]   start_col;

    fb_ram_reader #(
        .N_DRIVERS  (N_DRIVERS),
        .PIXEL_W    (PIXEL_W),
        .MUX        (MUX),
        .RAM_ADDR_W (RAM_ADDR_W),
        .RAM_LAT    (RAM_LAT),
        .CNT_W      (CNT_W),
        .COL_W      (COL_W)
    ) u_reader (
        .clk        (clk),
        .nrst       (nrst),
        .clk_enable (clk_enable),
        .flush      (SOF),
        .start      (start),
        .start_col  (start_col),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .fill_done  (fill_done)
    );

    // The first column of a slice never waits for the driver
    assign ready    = (col == '0) || pend || EOC;
    assign last_col = (col == COL_W'(MUX - 1));
    assign swap     = clk_enable && !SOF &&
                      (((state == FILL) && fill_done && ready) ||
                       ((state == SWAP_WAIT) && ready));
    assign start     = SOF || (swap && !last_col);
    assign start_col = SOF ? '0 : col + 1'b1;

    assign data_out = front_sel ? buf1 : buf0;

    // Back-buffer writes; the last word and the swap share one edge
    always_ff @(posedge clk) begin
        if (!nrst) begin
            buf0      <= '0;
            buf1      <= '0;
            front_sel <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < N_DRIVERS; k++) begin
                    if (wr_idx == CNT_W'(k)) begin
                        if (front_sel) begin
                            buf0[k*PIXEL_W +: PIXEL_W] <= wr_data;
                        end else begin
                            buf1[k*PIXEL_W +: PIXEL_W] <= wr_data;
                        end
                    end
                end
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // Fill/swap sequencing with registered status pulses
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            col        <= '0;
            pend       <= 1'b0;
            data_valid <= 1'b0;
            driver_SOF <= 1'b0;
            EOR        <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            driver_SOF <= 1'b0;
            EOR        <= 1'b0;
            underrun   <= 1'b0;
            if (SOF) begin
                state      <= FILL;
                col        <= '0;
                pend       <= 1'b0;
                data_valid <= 1'b0;
            end else begin
                if (EOC && (state == FILL) && !fill_done) begin
                    underrun <= 1'b1;
                end
                if (EOC && (state != IDLE) && !swap) begin
                    pend <= 1'b1;
                end
                if ((state == FILL) && fill_done && last_col) begin
                    EOR <= 1'b1;
                end
                if (swap) begin
                    pend       <= 1'b0;
                    data_valid <= 1'b1;
                    driver_SOF <= (col == '0);
                    if (last_col) begin
                        state <= IDLE;
                    end else begin
                        state <= FILL;
                        col   <= col + 1'b1;
                    end
                end else if (clk_enable) begin
                    unique case (state)
                        FILL: begin
                            if (fill_done) begin
                                state <= SWAP_WAIT;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
